tx_cfg_sched: RTL and testbench

- Configuration and commit controller for the per-channel TX mixer bank (CHANNEL x MIX_NUM mixers).
- The host writes phase coefficients (cos/sin) and frequency selects (choose) into a shadow bank.
- On request, the shadow bank is copied atomically into the active bank at the next frame boundary (iqpcm_valid), with a timeout fallback.
- Also collects the mixers' sticky err flags and sequences their err_clr pulses.

---
 rtl/tx_cfg_sched.sv | 168 ++++++++++++++++
 tb/tb_tx_cfg_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_cfg_sched.sv
// Shadow/active coefficient bank for the TX mixer array with frame-aligned
// atomic commit (timeout fallback) and sticky mixer error collection.
module tx_cfg_sched #(
  parameter int unsigned CHANNEL  = 8,
  parameter int unsigned FREQ_NUM = 6,
  parameter int unsigned MIX_NUM  = 3,
  parameter int unsigned sita_w   = 16,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic                               clk1,
  input  logic                               rst,
  input  logic                               wr_en,
  output logic                               wr_ready,
  input  logic [7:0]                         wr_addr,
  input  logic [2*sita_w+3:0]                wr_data,
  input  logic [7:0]                         rd_addr,
  output logic [2*sita_w+3:0]                rd_data,
  input  logic                               commit_req,
  input  logic                               iqpcm_valid,
  output logic                               busy,
  output logic                               commit_done,
  output logic                               commit_tmo,
  output logic                               cfg_err,
  output logic [sita_w*MIX_NUM*CHANNEL-1:0]  cos_sita,
  output logic [sita_w*MIX_NUM*CHANNEL-1:0]  sin_sita,
  output logic [4*MIX_NUM*CHANNEL-1:0]       choose,
  input  logic [CHANNEL-1:0]                 err,
  input  logic                               clr_req,
  input  logic [CHANNEL-1:0]                 clr_mask,
  output logic [CHANNEL-1:0]                 err_clr,
  output logic [CHANNEL-1:0]                 err_status,
  output logic                               err_irq
);

  localparam int unsigned ENTRIES = CHANNEL * MIX_NUM;
  localparam int unsigned DW      = 2 * sita_w + 4;
  localparam int unsigned AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int unsigned CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_APPLY
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_tmo;
  logic [DW-1:0]   r_shadow [ENTRIES];
  logic [DW-1:0]   r_active [ENTRIES];

  logic            w_wr_hit;
  logic            w_addr_ok;
  logic            w_sel_ok;
  logic            w_wr_ok;
  logic            w_wr_bad;
  logic [AW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_rd_idx;

  // wr_ready is high exactly in IDLE, so it doubles as the write gate
  assign w_wr_hit  = wr_en & wr_ready;
  assign w_addr_ok = (wr_addr < 8'(ENTRIES));
  assign w_sel_ok  = (wr_data[DW-1 -: 4] < 4'(FREQ_NUM));
  assign w_wr_ok   = w_wr_hit & w_addr_ok & w_sel_ok;
  assign w_wr_bad  = w_wr_hit & ~(w_addr_ok & w_sel_ok);
  assign w_wr_idx  = wr_addr[AW-1:0];
  assign w_rd_idx  = rd_addr[AW-1:0];

  // Shadow write shares the IDLE edge with commit_req, so the write is
  // already in the shadow by the time APPLY copies it.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tmo       <= 1'b0;
      wr_ready    <= 1'b1;
      busy        <= 1'b0;
      commit_done <= 1'b0;
      commit_tmo  <= 1'b0;
      for (int unsigned e = 0; e < ENTRIES; e++) begin
        r_shadow[e] <= '0;
        r_active[e] <= '0;
      end
    end else begin
      commit_done <= 1'b0;
      if (w_wr_ok) begin
        r_shadow[w_wr_idx] <= wr_data;
      end
      case (r_state)
        S_IDLE: begin
          if (commit_req) begin
            r_state  <= S_ARMED;
            r_cnt    <= '0;
            wr_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_ARMED: begin
          if (iqpcm_valid) begin
            r_state <= S_APPLY;
            r_tmo   <= 1'b0;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state <= S_APPLY;
            r_tmo   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_APPLY: begin
          for (int unsigned e = 0; e < ENTRIES; e++) begin
            r_active[e] <= r_shadow[e];
          end
          commit_done <= 1'b1;
          commit_tmo  <= r_tmo;
          r_state     <= S_IDLE;
          wr_ready    <= 1'b1;
          busy        <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          wr_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_addr < 8'(ENTRIES)) begin
      rd_data <= r_active[w_rd_idx];
    end else begin
      rd_data <= '0;
    end
  end

  // A rejected write in the same cycle as clr_req keeps cfg_err set
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      cfg_err    <= 1'b0;
      err_clr    <= '0;
      err_status <= '0;
      err_irq    <= 1'b0;
    end else begin
      if (w_wr_bad) begin
        cfg_err <= 1'b1;
      end else if (clr_req) begin
        cfg_err <= 1'b0;
      end
      err_clr    <= clr_req ? clr_mask : '0;
      err_status <= (err_status & ~(clr_req ? clr_mask : '0)) | err;
      err_irq    <= |err_status;
    end
  end

  always_comb begin
    cos_sita = '0;
    sin_sita = '0;
    choose   = '0;
    for (int unsigned e = 0; e < ENTRIES; e++) begin
      cos_sita[sita_w*e +: sita_w] = r_active[e][sita_w-1:0];
      sin_sita[sita_w*e +: sita_w] = r_active[e][2*sita_w-1:sita_w];
      choose[4*e +: 4]             = r_active[e][DW-1 -: 4];
    end
  end

endmodule

// File: tb/tb_tx_cfg_sched.sv
// Directed bench for tx_cfg_sched: commit latency, write validation,
// timeout fallback, error clearing and mid-commit reset.
module tb_tx_cfg_sched;

  logic         clk1;
  logic         rst;
  logic         wr_en;
  logic         wr_ready;
  logic [7:0]   wr_addr;
  logic [35:0]  wr_data;
  logic [7:0]   rd_addr;
  logic [35:0]  rd_data;
  logic         commit_req;
  logic         iqpcm_valid;
  logic         busy;
  logic         commit_done;
  logic         commit_tmo;
  logic         cfg_err;
  logic [383:0] cos_sita;
  logic [383:0] sin_sita;
  logic [95:0]  choose;
  logic [7:0]   err;
  logic         clr_req;
  logic [7:0]   clr_mask;
  logic [7:0]   err_clr;
  logic [7:0]   err_status;
  logic         err_irq;

  int n_total;
  int n_bad;

  tx_cfg_sched #(
    .CHANNEL (8),
    .FREQ_NUM(6),
    .MIX_NUM (3),
    .sita_w  (16),
    .TIMEOUT (4096)
  ) u_dut (
    .clk1       (clk1),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .commit_req (commit_req),
    .iqpcm_valid(iqpcm_valid),
    .busy       (busy),
    .commit_done(commit_done),
    .commit_tmo (commit_tmo),
    .cfg_err    (cfg_err),
    .cos_sita   (cos_sita),
    .sin_sita   (sin_sita),
    .choose     (choose),
    .err        (err),
    .clr_req    (clr_req),
    .clr_mask   (clr_mask),
    .err_clr    (err_clr),
    .err_status (err_status),
    .err_irq    (err_irq)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  initial begin
    logic [35:0] d5;
    logic [35:0] d23;
    int          n;
    logic        seen;

    n_total = 0;
    n_bad   = 0;
    d5  = {4'd2, 16'h1234, 16'h7FFF};
    d23 = {4'd5, 16'hABCD, 16'h8001};

    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    commit_req = 1'b0; iqpcm_valid = 1'b0; err = '0; clr_req = 1'b0; clr_mask = '0;
    repeat (3) tick();
    chk("rst_cos", cos_sita, '0);
    chk("rst_sin", sin_sita, '0);
    chk("rst_choose", choose, '0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_irq", err_irq, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    rst = 1'b1;
    tick();

    // normal commit, iqpcm_valid 10 cycles after commit_req
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = d5;
    tick();
    wr_en = 1'b0;
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    chk("armed_busy", busy, 1'b1);
    chk("armed_wr_ready", wr_ready, 1'b0);
    repeat (9) tick();
    chk("armed_choose_hold", choose, '0);
    iqpcm_valid = 1'b1;
    tick();
    iqpcm_valid = 1'b0;
    chk("apply_edge1_choose", choose, '0);
    chk("apply_edge1_done", commit_done, 1'b0);
    tick();
    chk("commit_choose5", choose[23:20], 4'd2);
    chk("commit_sin5", sin_sita[16*5 +: 16], 16'h1234);
    chk("commit_cos_all", cos_sita, {368'd0, 16'h7FFF} << 80);
    chk("commit_done_pulse", commit_done, 1'b1);
    chk("commit_tmo0", commit_tmo, 1'b0);
    chk("commit_busy_low", busy, 1'b0);
    rd_addr = 8'd5;
    tick();
    chk("commit_done_once", commit_done, 1'b0);
    chk("rd_e5", rd_data, d5);
    rd_addr = 8'd30;
    tick();
    chk("rd_oob", rd_data, '0);

    // rejected writes
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = {4'd6, 16'h1111, 16'h2222};
    tick();
    wr_en = 1'b0;
    chk("bad_choose_cfg_err", cfg_err, 1'b1);
    clr_req = 1'b1; clr_mask = 8'h00;
    tick();
    clr_req = 1'b0;
    chk("cfg_err_clr1", cfg_err, 1'b0);
    wr_en = 1'b1; wr_addr = 8'd24; wr_data = {4'd1, 16'h3333, 16'h4444};
    tick();
    wr_en = 1'b0;
    chk("bad_addr_cfg_err", cfg_err, 1'b1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("cfg_err_clr2", cfg_err, 1'b0);

    // timeout commit; write attempt during ARMED is dropped
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    wr_en = 1'b1; wr_addr = 8'd0; wr_data = {4'd1, 16'h5555, 16'h6666};
    n = 1;
    tick();
    wr_en = 1'b0;
    while (!commit_done && n < 5000) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, 4097);
    chk("tmo_flag", commit_tmo, 1'b1);
    chk("tmo_busy_low", busy, 1'b0);
    chk("tmo_cfg_err", cfg_err, 1'b0);
    chk("tmo_choose0", choose[3:0], 4'd0);
    chk("tmo_keep_cos5", cos_sita[16*5 +: 16], 16'h7FFF);
    chk("tmo_keep_choose5", choose[23:20], 4'd2);

    // iqpcm_valid on the last counted cycle wins; write lands with commit_req
    wr_en = 1'b1; wr_addr = 8'd23; wr_data = d23; commit_req = 1'b1;
    tick();
    wr_en = 1'b0; commit_req = 1'b0;
    repeat (4095) tick();
    chk("edge_busy", busy, 1'b1);
    chk("edge_no_done", commit_done, 1'b0);
    iqpcm_valid = 1'b1;
    tick();
    iqpcm_valid = 1'b0;
    tick();
    chk("edge_done", commit_done, 1'b1);
    chk("edge_tmo_cleared", commit_tmo, 1'b0);
    chk("edge_choose23", choose[95:92], 4'd5);
    chk("edge_sin23", sin_sita[16*23 +: 16], 16'hABCD);
    chk("edge_cos23", cos_sita[16*23 +: 16], 16'h8001);

    // error collection and clearing
    err = 8'h05;
    tick();
    err = 8'h00;
    chk("err_status_set", err_status, 8'h05);
    chk("err_irq_lag", err_irq, 1'b0);
    tick();
    chk("err_irq_set", err_irq, 1'b1);
    err = 8'h04; clr_req = 1'b1; clr_mask = 8'h01;
    tick();
    err = 8'h00; clr_req = 1'b0;
    chk("err_clr_pulse", err_clr, 8'h01);
    chk("err_status_part", err_status, 8'h04);
    tick();
    chk("err_clr_end", err_clr, 8'h00);
    chk("err_irq_hold", err_irq, 1'b1);
    err = 8'h04; clr_req = 1'b1; clr_mask = 8'h04;
    tick();
    err = 8'h00; clr_req = 1'b0;
    chk("err_set_wins", err_status, 8'h04);
    clr_req = 1'b1; clr_mask = 8'h04;
    tick();
    clr_req = 1'b0;
    chk("err_status_clr", err_status, 8'h00);
    tick();
    chk("err_irq_clr", err_irq, 1'b0);

    // reset while ARMED
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    repeat (3) tick();
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_cos", cos_sita, '0);
    chk("mid_rst_sin", sin_sita, '0);
    chk("mid_rst_choose", choose, '0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_wr_ready", wr_ready, 1'b1);
    tick();
    rst = 1'b1;
    seen = 1'b0;
    iqpcm_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      iqpcm_valid = 1'b0;
      seen = seen | commit_done;
    end
    chk("rst_no_done", seen, 1'b0);
    chk("rst_idle_busy", busy, 1'b0);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    iqpcm_valid = 1'b1;
    tick();
    iqpcm_valid = 1'b0;
    tick();
    chk("post_rst_done", commit_done, 1'b1);
    chk("post_rst_shadow_zero", choose, '0);
    chk("post_rst_cos_zero", cos_sita, '0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
